// File: rtl/spi_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_responder
//  Purpose  : SPI mode-0 SRAM target (READ 0x03 / WRITE 0x02, 16-bit address,
//             sequential mode) bridged onto a byte-wide parallel memory port.
//  Revision : 1.0  initial release
// ============================================================================
module spi_ram_responder #(
   parameter int ADDR_BITS   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_clk,
   input  logic                 spi_select,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_re,
   input  logic [7:0]           mem_rdata,
   output logic                 mem_we,
   output logic [7:0]           mem_wdata,
   output logic                 busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_READ   = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_IGNORE = 3'd5;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   // {spi_clk, spi_select, spi_mosi} after the synchronizer
   logic [2:0] w_sync;

   generate
      if (SYNC_STAGES > 0) begin : g_sync
         logic [2:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
            end else begin
               sync_q[0] <= {spi_clk, spi_select, spi_mosi};
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign w_sync = sync_q[SYNC_STAGES-1];
      end else begin : g_nosync
         assign w_sync = {spi_clk, spi_select, spi_mosi};
      end
   endgenerate

   logic w_sclk, w_sel, w_mosi;
   assign w_sclk = w_sync[2];
   assign w_sel  = w_sync[1];
   assign w_mosi = w_sync[0];

   logic                 sclk_prev_q, sel_prev_q;
   logic [2:0]           state_q,   state_d;
   logic [3:0]           cnt_q,     cnt_d;
   logic [14:0]          rx_q,      rx_d;
   logic [7:0]           tx_q,      tx_d;
   logic                 rd_mode_q, rd_mode_d;
   logic                 rd_cap_q,  rd_cap_d;
   logic                 miso_q,    miso_d;
   logic                 oe_q,      oe_d;
   logic [ADDR_BITS-1:0] addr_q,    addr_d;
   logic                 re_q,      re_d;
   logic                 we_q,      we_d;
   logic [7:0]           wdata_q,   wdata_d;
   logic                 busy_q,    busy_d;

   logic        w_rise, w_fall;
   logic [7:0]  w_byte, w_tx;
   logic [15:0] w_addr16;
   logic [3:0]  w_cnt_inc;

   assign w_rise    = w_sclk & ~sclk_prev_q;
   assign w_fall    = ~w_sclk & sclk_prev_q;
   assign w_byte    = {rx_q[6:0], w_mosi};
   assign w_addr16  = {rx_q[14:0], w_mosi};
   assign w_cnt_inc = cnt_q + 4'd1;
   // Read data may land in the same cycle as the falling edge that shifts it out
   assign w_tx      = rd_cap_q ? mem_rdata : tx_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      rd_mode_d = rd_mode_q;
      rd_cap_d  = re_q;
      miso_d    = miso_q;
      oe_d      = oe_q;
      addr_d    = addr_q;
      re_d      = 1'b0;
      we_d      = 1'b0;
      wdata_d   = wdata_q;
      busy_d    = busy_q;

      if (we_q) addr_d = addr_q + ADDR_BITS'(1);
      if (rd_cap_q) tx_d = mem_rdata;

      if (w_sel) begin
         state_d = S_IDLE;
         cnt_d   = 4'd0;
         miso_d  = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sel_prev_q) begin
                  state_d = S_CMD;
                  busy_d  = 1'b1;
                  cnt_d   = 4'd0;
               end
            end
            S_CMD: begin
               if (w_rise) begin
                  rx_d  = w_addr16[14:0];
                  cnt_d = w_cnt_inc;
                  if (cnt_q == 4'd7) begin
                     cnt_d = 4'd0;
                     if (w_byte == CMD_READ) begin
                        state_d   = S_ADDR;
                        rd_mode_d = 1'b1;
                     end else if (w_byte == CMD_WRITE) begin
                        state_d   = S_ADDR;
                        rd_mode_d = 1'b0;
                     end else begin
                        state_d   = S_IGNORE;
                     end
                  end
               end
            end
            S_ADDR: begin
               if (w_rise) begin
                  rx_d  = w_addr16[14:0];
                  cnt_d = w_cnt_inc;
                  if (cnt_q == 4'd15) begin
                     cnt_d  = 4'd0;
                     addr_d = w_addr16[ADDR_BITS-1:0];
                     if (rd_mode_q) begin
                        re_d    = 1'b1;
                        state_d = S_READ;
                     end else begin
                        state_d = S_WRITE;
                     end
                  end
               end
            end
            S_READ: begin
               if (w_rise) begin
                  cnt_d = (cnt_q == 4'd7) ? 4'd0 : w_cnt_inc;
                  // Bit 0 of the byte is going out: fetch the next byte now
                  if (cnt_q == 4'd7) begin
                     addr_d = addr_q + ADDR_BITS'(1);
                     re_d   = 1'b1;
                  end
               end
               if (w_fall) begin
                  miso_d = w_tx[7];
                  tx_d   = {w_tx[6:0], 1'b0};
                  oe_d   = 1'b1;
               end
            end
            S_WRITE: begin
               if (w_rise) begin
                  rx_d  = w_addr16[14:0];
                  cnt_d = w_cnt_inc;
                  if (cnt_q == 4'd7) begin
                     cnt_d   = 4'd0;
                     wdata_d = w_byte;
                     we_d    = 1'b1;
                  end
               end
            end
            default: begin
               state_d = S_IGNORE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_prev_q <= 1'b0;
         sel_prev_q  <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         rx_q        <= 15'd0;
         tx_q        <= 8'd0;
         rd_mode_q   <= 1'b0;
         rd_cap_q    <= 1'b0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         addr_q      <= '0;
         re_q        <= 1'b0;
         we_q        <= 1'b0;
         wdata_q     <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         sclk_prev_q <= w_sclk;
         sel_prev_q  <= w_sel;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         rd_mode_q   <= rd_mode_d;
         rd_cap_q    <= rd_cap_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         addr_q      <= addr_d;
         re_q        <= re_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign mem_addr    = addr_q;
   assign mem_re      = re_q;
   assign mem_we      = we_q;
   assign mem_wdata   = wdata_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram_responder
//  Purpose  : Self-checking bench for spi_ram_responder, SYNC_STAGES 2 and 0.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_ram_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic spi_clk = 1'b0, spi_select = 1'b1, spi_mosi = 1'b0;
   logic [7:0] mem_rdata = 8'd0;

   logic miso2, oe2, re2, we2, busy2, miso0, oe0, re0, we0, busy0;
   logic [15:0] addr2, addr0;
   logic [7:0]  wdata2, wdata0;

   spi_ram_responder #(.ADDR_BITS(16), .SYNC_STAGES(2)) u_dut_s2 (
      .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_select(spi_select),
      .spi_mosi(spi_mosi), .spi_miso(miso2), .spi_miso_oe(oe2), .mem_addr(addr2),
      .mem_re(re2), .mem_rdata(mem_rdata), .mem_we(we2), .mem_wdata(wdata2),
      .busy(busy2));

   spi_ram_responder #(.ADDR_BITS(16), .SYNC_STAGES(0)) u_dut_s0 (
      .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_select(spi_select),
      .spi_mosi(spi_mosi), .spi_miso(miso0), .spi_miso_oe(oe0), .mem_addr(addr0),
      .mem_re(re0), .mem_rdata(mem_rdata), .mem_we(we0), .mem_wdata(wdata0),
      .busy(busy0));

   // The instance under test in the current pass owns the memory port
   logic use0 = 1'b0;
   int   half = 4;
   int   sync = 2;

   logic        a_miso, a_oe, a_re, a_we, a_busy;
   logic [15:0] a_addr;
   logic [7:0]  a_wdata;
   assign a_miso  = use0 ? miso0  : miso2;
   assign a_oe    = use0 ? oe0    : oe2;
   assign a_re    = use0 ? re0    : re2;
   assign a_we    = use0 ? we0    : we2;
   assign a_busy  = use0 ? busy0  : busy2;
   assign a_addr  = use0 ? addr0  : addr2;
   assign a_wdata = use0 ? wdata0 : wdata2;

   logic [7:0]  mem [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_a = 16'd0;
   logic [7:0]  pl_d = 8'd0;
   logic [23:0] we_log [$];
   logic [15:0] re_log [$];
   int re_cnt = 0, we_cnt = 0, oe_cnt = 0, clash_cnt = 0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_a] <= pl_d;
      if (a_we)  mem[a_addr] <= a_wdata;
      if (a_re)  mem_rdata <= mem[a_addr];
      if (a_re) begin re_cnt <= re_cnt + 1; re_log.push_back(a_addr); end
      if (a_we) begin we_cnt <= we_cnt + 1; we_log.push_back({a_addr, a_wdata}); end
      if (a_oe) oe_cnt <= oe_cnt + 1;
      if (a_re && a_we) clash_cnt <= clash_cnt + 1;
   end

   int total = 0, bad = 0;
   int re_at_rise = 0;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      pl_a = a; pl_d = d; pl_en = 1'b1;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic spi_bit(input logic b, output logic r);
      spi_mosi = b;
      wait_clk(half);
      r = a_miso;
      re_at_rise = re_cnt;
      spi_clk = 1'b1;
      wait_clk(half);
      spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] o, output logic [7:0] i);
      logic bt;
      for (int k = 7; k >= 0; k--) begin
         spi_bit(o[k], bt);
         i[k] = bt;
      end
   endtask

   task automatic run_txn(input logic [7:0] cmd, input logic [15:0] addr,
                          input logic [7:0] tx[$], output logic [7:0] rx[$]);
      logic [7:0] dummy, b;
      rx = {};
      spi_select = 1'b0;
      wait_clk(half);
      spi_byte(cmd, dummy);
      spi_byte(addr[15:8], dummy);
      spi_byte(addr[7:0], dummy);
      foreach (tx[k]) begin
         spi_byte(tx[k], b);
         rx.push_back(b);
      end
   endtask

   task automatic end_txn();
      wait_clk(half);
      spi_select = 1'b1;
      wait_clk(sync + 4);
   endtask

   task automatic test_reset();
      spi_clk = 1'b0; spi_select = 1'b1; spi_mosi = 1'b0;
      rst_n = 1'b0;
      wait_clk(3);
      total++;
      if ({a_miso, a_oe, a_re, a_we, a_busy, a_addr, a_wdata} !== 29'd0) begin
         bad++; $display("FAIL reset_state[S%0d]: got %h want 0", sync,
                         {a_miso, a_oe, a_re, a_we, a_busy, a_addr, a_wdata});
      end
      // select falls in the same cycle reset releases: must not start a transaction
      spi_select = 1'b0;
      rst_n = 1'b1;
      wait_clk(sync + 6);
      total++;
      if (a_busy !== 1'b0) begin
         bad++; $display("FAIL reset_release_select[S%0d]: busy got %b want 0", sync, a_busy);
      end
      spi_select = 1'b1;
      wait_clk(sync + 4);
   endtask

   task automatic test_write();
      logic [7:0] d[$], r[$];
      logic [15:0] a, ea;
      int wb, n;
      for (int t = 0; t < 4; t++) begin
         d = {};
         if (t == 0) begin
            a = 16'h1234; d.push_back(8'hBE); d.push_back(8'hEF);
         end else begin
            a = 16'($urandom);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
         end
         wb = we_log.size();
         run_txn(8'h02, a, d, r);
         total++;
         if (a_busy !== 1'b1) begin
            bad++; $display("FAIL write_busy[S%0d]: got %b want 1", sync, a_busy);
         end
         wait_clk(half);
         spi_select = 1'b1;
         repeat (sync + 1) @(posedge clk);
         #1;
         total++;
         if (a_busy !== 1'b0) begin
            bad++; $display("FAIL write_busy_drop[S%0d]: got %b want 0", sync, a_busy);
         end
         wait_clk(4);
         total++;
         if (we_log.size() - wb != d.size()) begin
            bad++; $display("FAIL write_count[S%0d]: got %0d want %0d", sync,
                            we_log.size() - wb, d.size());
         end else begin
            foreach (d[k]) begin
               ea = a + 16'(k);
               total++;
               if (we_log[wb + k] !== {ea, d[k]}) begin
                  bad++; $display("FAIL write_entry[S%0d]: got %h want %h", sync,
                                  we_log[wb + k], {ea, d[k]});
               end
            end
         end
      end
   endtask

   task automatic test_read();
      logic [7:0] d[$], r[$], e[$];
      logic [15:0] a;
      int rb, wc, n;
      for (int t = 0; t < 4; t++) begin
         e = {}; d = {};
         if (t == 0) begin
            a = 16'h1234; e.push_back(8'hBE); e.push_back(8'hEF);
         end else begin
            a = 16'($urandom);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) e.push_back(8'($urandom));
         end
         foreach (e[k]) begin
            preload(a + 16'(k), e[k]);
            d.push_back(8'h00);
         end
         rb = re_log.size();
         wc = we_cnt;
         run_txn(8'h03, a, d, r);
         total++;
         if (re_at_rise - rb != e.size()) begin
            bad++; $display("FAIL read_re_count[S%0d]: got %0d want %0d", sync,
                            re_at_rise - rb, e.size());
         end
         end_txn();
         foreach (e[k]) begin
            total++;
            if (r[k] !== e[k]) begin
               bad++; $display("FAIL read_data[S%0d]: got %h want %h", sync, r[k], e[k]);
            end
            total++;
            if (re_log[rb + k] !== a + 16'(k)) begin
               bad++; $display("FAIL read_addr[S%0d]: got %h want %h", sync,
                               re_log[rb + k], a + 16'(k));
            end
         end
         total++;
         if (we_cnt != wc) begin
            bad++; $display("FAIL read_no_write[S%0d]: got %0d want %0d", sync, we_cnt, wc);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] d[$], r[$];
      int wb, rb;
      d = {8'hA5, 8'h5A};
      wb = we_log.size();
      run_txn(8'h02, 16'hFFFF, d, r);
      end_txn();
      total++;
      if (we_log.size() - wb != 2 || we_log[wb] !== 24'hFFFFA5 || we_log[wb + 1] !== 24'h00005A) begin
         bad++; $display("FAIL wrap_write[S%0d]: got %0d entries, first %h want FFFFA5,00005A",
                         sync, we_log.size() - wb, we_log[wb]);
      end
      d = {8'h00, 8'h00};
      rb = re_log.size();
      run_txn(8'h03, 16'hFFFF, d, r);
      end_txn();
      total++;
      if (r[0] !== 8'hA5 || r[1] !== 8'h5A || re_log[rb + 1] !== 16'h0000) begin
         bad++; $display("FAIL wrap_read[S%0d]: got %h%h addr %h want A55A addr 0000",
                         sync, r[0], r[1], re_log[rb + 1]);
      end
   endtask

   task automatic test_ignore();
      logic [7:0] d[$], r[$];
      logic [7:0] c;
      int rc, wc, oc;
      for (int t = 0; t < 3; t++) begin
         c = (t == 0) ? 8'h05 : 8'($urandom);
         if (c == 8'h02 || c == 8'h03) c = 8'hFF;
         d = {8'($urandom)};
         rc = re_cnt; wc = we_cnt; oc = oe_cnt;
         run_txn(c, 16'($urandom), d, r);
         end_txn();
         total++;
         if (re_cnt != rc || we_cnt != wc) begin
            bad++; $display("FAIL ignore_mem[S%0d] cmd %h: got re=%0d we=%0d want 0 0",
                            sync, c, re_cnt - rc, we_cnt - wc);
         end
         total++;
         if (oe_cnt != oc || r[0] !== 8'h00) begin
            bad++; $display("FAIL ignore_miso[S%0d] cmd %h: got oe_cycles=%0d miso=%h want 0 00",
                            sync, c, oe_cnt - oc, r[0]);
         end
      end
   endtask

   task automatic test_abort();
      logic [7:0] d[$], r[$];
      logic [7:0] b0, pv;
      logic [15:0] a;
      logic bt;
      int wb;
      a  = 16'($urandom);
      b0 = 8'($urandom);
      pv = ~b0;
      preload(a + 16'd1, pv);
      wb = we_log.size();
      d = {b0};
      run_txn(8'h02, a, d, r);
      for (int k = 0; k < 4; k++) spi_bit(1'($urandom), bt);
      end_txn();
      total++;
      if (we_log.size() - wb != 1 || we_log[wb] !== {a, b0}) begin
         bad++; $display("FAIL abort_write[S%0d]: got %0d entries, first %h want 1 entry %h",
                         sync, we_log.size() - wb, we_log[wb], {a, b0});
      end
      d = {8'h00, 8'h00};
      run_txn(8'h03, a, d, r);
      end_txn();
      total++;
      if (r[0] !== b0 || r[1] !== pv) begin
         bad++; $display("FAIL abort_readback[S%0d]: got %h%h want %h%h", sync, r[0], r[1], b0, pv);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d[$], r[$];
      logic [15:0] a;
      int wb;
      a = 16'($urandom);
      d = {8'($urandom), 8'($urandom)};
      wb = we_log.size();
      run_txn(8'h02, a, d, r);
      wait_clk(half);
      spi_select = 1'b1;
      wait_clk(1);
      run_txn(8'h03, a, '{8'h00, 8'h00}, r);
      end_txn();
      total++;
      if (we_log.size() - wb != 2) begin
         bad++; $display("FAIL b2b_write_count[S%0d]: got %0d want 2", sync, we_log.size() - wb);
      end
      total++;
      if (r[0] !== d[0] || r[1] !== d[1]) begin
         bad++; $display("FAIL b2b_read[S%0d]: got %h%h want %h%h", sync, r[0], r[1], d[0], d[1]);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] d[$], r[$];
      logic bt;
      preload(16'h1234, 8'hBE);
      preload(16'h1235, 8'hEF);
      d = {};
      run_txn(8'h03, 16'h1234, d, r);
      for (int k = 0; k < 5; k++) spi_bit(1'b0, bt);
      spi_mosi = 1'b0;
      wait_clk(half);
      spi_clk = 1'b1;
      wait_clk(1);
      total++;
      if (a_oe !== 1'b1 || a_busy !== 1'b1) begin
         bad++; $display("FAIL areset_pre[S%0d]: oe=%b busy=%b want 1 1", sync, a_oe, a_busy);
      end
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({a_miso, a_oe, a_re, a_we, a_busy, a_addr, a_wdata} !== 29'd0) begin
         bad++; $display("FAIL areset_outputs[S%0d]: got %h want 0", sync,
                         {a_miso, a_oe, a_re, a_we, a_busy, a_addr, a_wdata});
      end
      spi_clk = 1'b0;
      spi_select = 1'b1;
      wait_clk(3);
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_clk(sync + 4);
      d = {8'h00, 8'h00};
      run_txn(8'h03, 16'h1234, d, r);
      end_txn();
      total++;
      if (r[0] !== 8'hBE || r[1] !== 8'hEF) begin
         bad++; $display("FAIL areset_fresh_read[S%0d]: got %h%h want BEEF", sync, r[0], r[1]);
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      for (int p = 0; p < 2; p++) begin
         use0 = (p == 1);
         sync = (p == 1) ? 0 : 2;
         half = (p == 1) ? 2 : 4;
         test_reset();
         test_write();
         test_read();
         test_wrap();
         test_ignore();
         test_abort();
         test_back_to_back();
         test_async_reset();
      end
      total++;
      if (clash_cnt != 0) begin
         bad++; $display("FAIL re_we_clash: got %0d cycles want 0", clash_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
